// File: rtl/health_manager_pkg.sv
// Shared definitions for the health manager and the OLED health-bar renderer:
// state encoding, default tuning values and bar colour thresholds.
package health_manager_pkg;

  localparam int HEALTH_W = 8;

  localparam logic [1:0] ST_ALIVE  = 2'd0;
  localparam logic [1:0] ST_INVULN = 2'd1;
  localparam logic [1:0] ST_DEAD   = 2'd2;

  localparam int DEFAULT_MAX_HEALTH   = 100;
  localparam int DEFAULT_IFRAME_TICKS = 30;
  localparam int DEFAULT_REGEN_TICKS  = 60;

  localparam int BAR_RED_BELOW    = 20;
  localparam int BAR_YELLOW_BELOW = 50;

  typedef enum logic [1:0] {
    BAR_RED    = 2'd0,
    BAR_YELLOW = 2'd1,
    BAR_GREEN  = 2'd2
  } bar_colour_t;

  function automatic bar_colour_t bar_colour(input logic [31:0] level);
    bar_colour_t c;
    if (level < 32'(BAR_RED_BELOW))         c = BAR_RED;
    else if (level < 32'(BAR_YELLOW_BELOW)) c = BAR_YELLOW;
    else                                    c = BAR_GREEN;
    return c;
  endfunction

  // Clamp a signed 10-bit intermediate into 0..max_h.
  function automatic logic [HEALTH_W-1:0] clamp_health(input logic signed [9:0] v,
                                                       input logic [HEALTH_W-1:0] max_h);
    logic [HEALTH_W-1:0] r;
    if (v < 10'sd0)                          r = '0;
    else if (v > $signed({2'b00, max_h}))    r = max_h;
    else                                     r = v[HEALTH_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/health_manager_tick_timer.sv
// Loadable down-counter advanced only on tick. A count of 0 means "idle": the
// next enabled tick starts a fresh PERIOD, so a cleared timer needs no reload.
module tick_timer #(
  parameter int PERIOD = 30,
  parameter int W      = $clog2(PERIOD + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic en,
  input  logic load,
  input  logic clear,
  output logic done
);

  localparam logic [W-1:0] PERIOD_W = W'(PERIOD);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_cur;

  assign count_cur = (count_reg == '0) ? PERIOD_W : count_reg;
  assign done      = en && tick && (count_cur == W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            count_reg <= '0;
    else if (clear)       count_reg <= '0;
    else if (load)        count_reg <= PERIOD_W;
    else if (en && tick)  count_reg <= count_cur - W'(1);
  end

endmodule

// File: rtl/health_manager.sv
// Owns the player health value: saturating damage/heal/revive, timed
// invincibility after hits and periodic regeneration, all outputs registered.
module health_manager
  import health_manager_pkg::*;
#(
  parameter int MAX_HEALTH   = DEFAULT_MAX_HEALTH,
  parameter int IFRAME_TICKS = DEFAULT_IFRAME_TICKS,
  parameter int REGEN_TICKS  = DEFAULT_REGEN_TICKS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        dmg_valid,
  input  logic [7:0]  dmg_amt,
  input  logic        heal_valid,
  input  logic [7:0]  heal_amt,
  input  logic        revive,
  output logic        dmg_ack,
  output logic [31:0] health_level,
  output logic        alive,
  output logic        invincible,
  output logic        hit_pulse,
  output logic        death_pulse
);

  localparam logic [HEALTH_W-1:0] MAX_H = HEALTH_W'(MAX_HEALTH);

  logic [1:0]          state_reg, state_next;
  logic [HEALTH_W-1:0] health_reg, health_next;
  logic                dmg_ack_reg, dmg_ack_next;
  logic                hit_reg, hit_next;
  logic                death_reg, death_next;
  logic                alive_reg, invincible_reg;

  logic [7:0]        dmg_term, heal_term;
  logic signed [9:0] net_alive, net_heal;
  logic              dmg_hit, iframe_load, iframe_en, iframe_done;
  logic              regen_en, regen_clear, regen_done;

  assign dmg_term  = dmg_valid  ? dmg_amt  : 8'd0;
  assign heal_term = heal_valid ? heal_amt : 8'd0;
  assign net_alive = $signed({2'b00, health_reg}) + $signed({2'b00, heal_term})
                   - $signed({2'b00, dmg_term});
  assign net_heal  = $signed({2'b00, health_reg}) + $signed({2'b00, heal_term});

  assign dmg_hit     = (state_reg == ST_ALIVE) && dmg_valid && (dmg_amt != 8'd0);
  assign iframe_en   = (state_reg == ST_INVULN);
  assign regen_en    = (state_reg == ST_ALIVE) && (health_reg < MAX_H);
  assign regen_clear = !regen_en || dmg_hit;

  tick_timer #(.PERIOD(IFRAME_TICKS)) u_iframe_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .en    (iframe_en),
    .load  (iframe_load),
    .clear (1'b0),
    .done  (iframe_done)
  );

  tick_timer #(.PERIOD(REGEN_TICKS)) u_regen_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .en    (regen_en),
    .load  (1'b0),
    .clear (regen_clear),
    .done  (regen_done)
  );

  always_comb begin
    state_next   = state_reg;
    health_next  = health_reg;
    dmg_ack_next = dmg_valid;
    hit_next     = 1'b0;
    death_next   = 1'b0;
    iframe_load  = 1'b0;
    case (state_reg)
      ST_ALIVE: begin
        // Any damage or heal request pre-empts a regen step landing this cycle.
        if (dmg_valid || heal_valid) begin
          health_next = clamp_health(net_alive, MAX_H);
          if (dmg_hit) begin
            hit_next = 1'b1;
            if (net_alive <= 10'sd0) begin
              state_next = ST_DEAD;
              death_next = 1'b1;
            end else begin
              state_next  = ST_INVULN;
              iframe_load = 1'b1;
            end
          end
        end else if (regen_done) begin
          health_next = health_reg + HEALTH_W'(1);
        end
      end
      ST_INVULN: begin
        if (heal_valid) health_next = clamp_health(net_heal, MAX_H);
        if (iframe_done) state_next = ST_ALIVE;
      end
      ST_DEAD: begin
        health_next = '0;
        if (revive) begin
          health_next = MAX_H;
          state_next  = ST_INVULN;
          iframe_load = 1'b1;
        end
      end
      default: begin
        state_next = ST_ALIVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_ALIVE;
      health_reg     <= MAX_H;
      dmg_ack_reg    <= 1'b0;
      hit_reg        <= 1'b0;
      death_reg      <= 1'b0;
      alive_reg      <= 1'b1;
      invincible_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      health_reg     <= health_next;
      dmg_ack_reg    <= dmg_ack_next;
      hit_reg        <= hit_next;
      death_reg      <= death_next;
      alive_reg      <= (state_next != ST_DEAD);
      invincible_reg <= (state_next == ST_INVULN);
    end
  end

  assign health_level = {{(32-HEALTH_W){1'b0}}, health_reg};
  assign dmg_ack      = dmg_ack_reg;
  assign hit_pulse    = hit_reg;
  assign death_pulse  = death_reg;
  assign alive        = alive_reg;
  assign invincible   = invincible_reg;

endmodule

// File: tb/tb_health_manager.sv
// Directed walk through the health manager behaviours followed by random
// traffic, every cycle compared against a behavioural model of the rules.
module tb_health_manager;

  localparam int MAXH   = 100;
  localparam int IFRAME = 30;
  localparam int REGEN  = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        dmg_valid;
  logic [7:0]  dmg_amt;
  logic        heal_valid;
  logic [7:0]  heal_amt;
  logic        revive;
  logic        dmg_ack;
  logic [31:0] health_level;
  logic        alive;
  logic        invincible;
  logic        hit_pulse;
  logic        death_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_h;
  bit m_dead;
  int m_inv;
  int m_regen;
  bit e_ack, e_hit, e_death;

  health_manager #(
    .MAX_HEALTH   (MAXH),
    .IFRAME_TICKS (IFRAME),
    .REGEN_TICKS  (REGEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .dmg_valid    (dmg_valid),
    .dmg_amt      (dmg_amt),
    .heal_valid   (heal_valid),
    .heal_amt     (heal_amt),
    .revive       (revive),
    .dmg_ack      (dmg_ack),
    .health_level (health_level),
    .alive        (alive),
    .invincible   (invincible),
    .hit_pulse    (hit_pulse),
    .death_pulse  (death_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = MAXH; m_dead = 0; m_inv = 0; m_regen = 0;
    e_ack = 0; e_hit = 0; e_death = 0;
  endtask

  task automatic model_step(input bit t, input bit dv, input logic [7:0] da,
                            input bit hv, input logic [7:0] ha, input bit rv);
    int n;
    bit eligible;
    e_ack = dv; e_hit = 0; e_death = 0;
    if (m_dead) begin
      if (rv) begin m_dead = 0; m_h = MAXH; m_inv = IFRAME; end
      m_regen = 0;
    end else if (m_inv > 0) begin
      if (hv) m_h = (m_h + int'(ha) > MAXH) ? MAXH : m_h + int'(ha);
      if (t) m_inv--;
      m_regen = 0;
    end else begin
      eligible = (m_h < MAXH);
      if (!eligible) m_regen = 0;
      if (dv || hv) begin
        n = m_h + (hv ? int'(ha) : 0) - (dv ? int'(da) : 0);
        m_h = (n < 0) ? 0 : ((n > MAXH) ? MAXH : n);
        if (t && eligible) begin
          m_regen++;
          if (m_regen == REGEN) m_regen = 0;
        end
        if (dv && da != 8'd0) begin
          e_hit = 1; m_regen = 0;
          if (m_h == 0) begin m_dead = 1; e_death = 1; end
          else m_inv = IFRAME;
        end
      end else if (t && eligible) begin
        m_regen++;
        if (m_regen == REGEN) begin m_regen = 0; m_h++; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_health"},  health_level, 32'(m_h));
    chk({tag, "_alive"},   {31'd0, alive},       {31'd0, !m_dead});
    chk({tag, "_invinc"},  {31'd0, invincible},  {31'd0, (!m_dead && m_inv > 0)});
    chk({tag, "_ack"},     {31'd0, dmg_ack},     {31'd0, e_ack});
    chk({tag, "_hit"},     {31'd0, hit_pulse},   {31'd0, e_hit});
    chk({tag, "_death"},   {31'd0, death_pulse}, {31'd0, e_death});
  endtask

  task automatic cycle_step(input bit t, input bit dv, input logic [7:0] da,
                            input bit hv, input logic [7:0] ha, input bit rv,
                            input string tag);
    tick = t; dmg_valid = dv; dmg_amt = da;
    heal_valid = hv; heal_amt = ha; revive = rv;
    model_step(t, dv, da, hv, ha, rv);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) cycle_step(1, 0, 8'd0, 0, 8'd0, 0, "tick");
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick = 0; dmg_valid = 0; dmg_amt = 0; heal_valid = 0; heal_amt = 0; revive = 0;
    model_reset();
    #2;
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick = 0; dmg_valid = 0; dmg_amt = 0; heal_valid = 0; heal_amt = 0; revive = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_health", health_level, 32'd100);
    chk("reset_alive", {31'd0, alive}, 32'd1);
    reset = 1'b0;

    // First hit: 30 damage, then invincibility expires after 30 ticks
    cycle_step(0, 1, 8'd30, 0, 8'd0, 0, "hit30");
    chk("hit30_level", health_level, 32'd70);
    chk("hit30_hitpulse", {31'd0, hit_pulse}, 32'd1);
    chk("hit30_invinc", {31'd0, invincible}, 32'd1);
    cycle_step(0, 0, 8'd0, 0, 8'd0, 0, "idle");
    chk("hit30_pulse_gone", {31'd0, hit_pulse}, 32'd0);
    cycle_step(0, 1, 8'd50, 0, 8'd0, 0, "inv_dmg");
    chk("inv_dmg_ack", {31'd0, dmg_ack}, 32'd1);
    chk("inv_dmg_level", health_level, 32'd70);
    chk("inv_dmg_nohit", {31'd0, hit_pulse}, 32'd0);
    run_ticks(29);
    chk("iframe_29", {31'd0, invincible}, 32'd1);
    run_ticks(1);
    chk("iframe_30", {31'd0, invincible}, 32'd0);

    // Overkill death, heal ignored while dead, revive
    cycle_step(0, 1, 8'd60, 0, 8'd0, 0, "to10");
    run_ticks(IFRAME);
    chk("at10", health_level, 32'd10);
    cycle_step(0, 1, 8'd255, 0, 8'd0, 0, "kill");
    chk("kill_level", health_level, 32'd0);
    chk("kill_death", {31'd0, death_pulse}, 32'd1);
    chk("kill_alive", {31'd0, alive}, 32'd0);
    cycle_step(0, 0, 8'd0, 0, 8'd0, 0, "dead_idle");
    chk("death_one_cycle", {31'd0, death_pulse}, 32'd0);
    cycle_step(0, 0, 8'd0, 1, 8'd50, 0, "dead_heal");
    chk("dead_heal_level", health_level, 32'd0);
    cycle_step(0, 1, 8'd5, 0, 8'd0, 0, "dead_dmg");
    cycle_step(0, 0, 8'd0, 0, 8'd0, 1, "revive");
    chk("revive_level", health_level, 32'd100);
    chk("revive_invinc", {31'd0, invincible}, 32'd1);
    run_ticks(IFRAME);

    // Heal saturation and simultaneous damage + heal
    cycle_step(0, 1, 8'd5, 0, 8'd0, 0, "to95");
    cycle_step(0, 0, 8'd0, 1, 8'd20, 0, "heal_sat");
    chk("heal_sat_level", health_level, 32'd100);
    run_ticks(IFRAME);
    cycle_step(0, 1, 8'd60, 0, 8'd0, 0, "to40");
    run_ticks(IFRAME);
    cycle_step(0, 1, 8'd10, 1, 8'd25, 0, "net");
    chk("net_level", health_level, 32'd55);
    chk("net_hit", {31'd0, hit_pulse}, 32'd1);
    run_ticks(IFRAME);

    // Zero-damage request in ALIVE: acknowledged, nothing else changes
    cycle_step(0, 1, 8'd0, 0, 8'd0, 0, "zero_dmg");
    chk("zero_dmg_ack", {31'd0, dmg_ack}, 32'd1);
    chk("zero_dmg_invinc", {31'd0, invincible}, 32'd0);

    // Regeneration from 98 up to the cap
    cycle_step(0, 0, 8'd0, 1, 8'd43, 0, "to98");
    chk("at98", health_level, 32'd98);
    run_ticks(REGEN - 1);
    chk("regen_not_yet", health_level, 32'd98);
    run_ticks(1);
    chk("regen_99", health_level, 32'd99);
    run_ticks(REGEN);
    chk("regen_100", health_level, 32'd100);
    run_ticks(REGEN);
    chk("regen_cap", health_level, 32'd100);

    // Asynchronous reset in the middle of invincibility
    cycle_step(0, 1, 8'd80, 0, 8'd0, 0, "to20");
    run_ticks(5);
    chk("pre_reset_level", health_level, 32'd20);
    do_reset("mid_inv");
    chk("mid_inv_level", health_level, 32'd100);
    chk("mid_inv_invinc", {31'd0, invincible}, 32'd0);
    chk("mid_inv_alive", {31'd0, alive}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit          t, dv, hv, rv;
      logic [7:0]  da, ha;
      t  = ($urandom_range(0, 1) == 0);
      dv = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 7))
        0:       da = 8'd0;
        1:       da = 8'd255;
        default: da = 8'($urandom_range(1, 40));
      endcase
      hv = ($urandom_range(0, 49) == 0);
      ha = 8'($urandom_range(0, 30));
      rv = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1499) == 0) do_reset("rnd_reset");
      else cycle_step(t, dv, da, hv, ha, rv, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/health_manager.md
# health_manager

Sequential owner of the player health value that the OLED health-bar renderer consumes. Accepts damage, heal and revive events from game logic and applies saturating arithmetic. Runs timed invincibility after hits and periodic regeneration. Presents a registered `health_level` plus status flags each cycle, so the renderer and game FSMs read a single, stable source.

## Interface
Parameters:
- `MAX_HEALTH`, default 100: full-health value; the reset and revive value.
- `IFRAME_TICKS`, default 30: number of `tick` pulses of invincibility after a hit or a revive.
- `REGEN_TICKS`, default 60: number of `tick` pulses between +1 regeneration steps.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: single-cycle game-frame strobe; all timers count only on this strobe.
- `dmg_valid`, in, 1: damage request.
- `dmg_amt`, in, 8: damage amount.
- `heal_valid`, in, 1: heal request.
- `heal_amt`, in, 8: heal amount.
- `revive`, in, 1: single-cycle revive request.
- `dmg_ack`, out, 1: one-cycle pulse when a damage request is accepted.
- `health_level`, out, 32: current health, 0..`MAX_HEALTH`; upper bits are always 0.
- `alive`, out, 1: high in `ALIVE` and `INVULN`.
- `invincible`, out, 1: high in `INVULN`.
- `hit_pulse`, out, 1: one-cycle pulse on applied damage.
- `death_pulse`, out, 1: one-cycle pulse on entry to `DEAD`.

## Operation
- The FSM has three states: `ALIVE`, `INVULN` and `DEAD`.
- `ALIVE`:
  - Damage applies when `dmg_valid` is high. Health becomes max(health − `dmg_amt`, 0) and the block pulses `dmg_ack` and `hit_pulse`.
  - If the result is 0, go to `DEAD` and pulse `death_pulse`. Otherwise load the iframe counter with `IFRAME_TICKS` and go to `INVULN`.
- `INVULN`:
  - A `dmg_valid` request is acknowledged with `dmg_ack`, but damage is not applied and `hit_pulse` stays low.
  - The iframe counter decrements on each `tick`. On the `tick` where the counter reaches 0, go to `ALIVE`.
- Heal, in `ALIVE` or `INVULN`: health becomes min(health + `heal_amt`, `MAX_HEALTH`).
- Simultaneous damage and heal in `ALIVE`: net = health + heal − dmg, evaluated in 10-bit signed arithmetic and clamped to 0..`MAX_HEALTH`.
  - The net value decides death.
  - `hit_pulse` fires only if `dmg_amt` is not 0.
- Regeneration:
  - The regen counter runs only in `ALIVE` with health < `MAX_HEALTH`, counting `tick` pulses.
  - At `REGEN_TICKS` it adds +1 (saturating) and clears.
  - The counter clears on any applied damage and on leaving `ALIVE`.
  - If a regen step and an event land in the same cycle, the event is applied first and the regen step is dropped.
- `DEAD`:
  - Health is held at 0. Damage is acknowledged and ignored; heal is ignored.
  - `revive` sets health to `MAX_HEALTH`, loads the iframe counter and goes to `INVULN`.
  - `revive` is ignored in all other states.
- `dmg_amt` of 0 in `ALIVE` is acknowledged and health is unchanged.
  - State is unchanged: no `INVULN` entry, no `hit_pulse`.

## Timing
- All outputs are registered. Events sampled at edge N appear on the outputs after edge N.
- `dmg_ack`, `hit_pulse` and `death_pulse` are high for exactly the one cycle after edge N.
- `dmg_valid` is acknowledged in every state, so an upstream request never stalls for more than one cycle.
- Holding `dmg_valid` high is treated as a new request every cycle.
- Timers change only on cycles where `tick` is high. An event and a `tick` in the same cycle: the event is processed and the timer reload wins.
- Reset (asynchronous, any time, including mid-`INVULN` or `DEAD`) forces:
  - `health_level` = `MAX_HEALTH`
  - state `ALIVE`
  - both counters 0
  - `alive` = 1
  - `invincible`, `dmg_ack`, `hit_pulse`, `death_pulse` = 0

## Structure
- A shared package holds:
  - the state encoding (`ALIVE`, `INVULN`, `DEAD`, 2 bits)
  - the default values of `MAX_HEALTH`, `IFRAME_TICKS` and `REGEN_TICKS`
  - the health-bar colour thresholds (20/50), so this block and the renderer agree.
- One natural sub-module, `tick_timer`: a loadable down-counter advanced by `tick`, with a `done` output. It is instantiated twice, for the iframe timer and the regen timer.

## Test plan
- Reset, then `dmg_valid`/`dmg_amt` = 30 -> `health_level` = 70, `hit_pulse` and `dmg_ack` each high 1 cycle, `invincible` = 1; after 30 ticks `invincible` = 0.
- In `INVULN`, `dmg_amt` = 50 -> `dmg_ack` = 1, `health_level` stays 70, no `hit_pulse`.
- Health 10 in `ALIVE`, `dmg_amt` = 255 -> `health_level` = 0, `death_pulse` for 1 cycle, `alive` = 0; then heal 50 -> stays 0; `revive` -> 100 with `invincible` = 1.
- Health 95, heal 20 -> 100 (saturates). Health 40 with dmg 10 and heal 25 in the same cycle -> 55 with `hit_pulse`.
- Health 98 in `ALIVE` with no events, 60 ticks -> 99; 60 more -> 100; 60 more -> 100 (no wrap).
- Assert `reset` mid-`INVULN` with health 20 -> next cycle shows `health_level` = 100, `invincible` = 0, `alive` = 1.
